// File: rtl/adder_eval_pkg.sv
// Shared types and width helpers for the approximate-adder error sweep.
package adder_eval_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // Default geometry: 8 input bits split into two 4-bit operands.
  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = DEF_IN_W / 2 + 1;
  localparam int DEF_ACC_W = DEF_IN_W + DEF_OUT_W;

  // Exact sum of two IN_W/2-bit operands needs one carry bit on top.
  function automatic int out_w_for(input int in_w);
    return in_w / 2 + 1;
  endfunction

  // Width of the |err| accumulator: 2^in_w terms of at most 2^out_w-1 each.
  function automatic int acc_w_for(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/sweep_tag_pipe.sv
// LAT-deep valid+vector delay line; keeps each issued vector aligned with
// the DUT result it produced. Collapses to wires when LAT is zero.
module sweep_tag_pipe #(
  parameter int LAT = 0,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] vec_i,
  output logic         valid_o,
  output logic [W-1:0] vec_o,
  output logic         pending_o
);

  if (LAT == 0) begin : g_pass
    // A combinational DUT answers in the same cycle; nothing is ever in flight.
    logic unused_pass;
    assign unused_pass = ^{clk, rst, flush_i};
    assign valid_o     = valid_i;
    assign vec_o       = vec_i;
    assign pending_o   = 1'b0;
  end else begin : g_pipe
    logic [LAT-1:0] valid_q;
    logic [W-1:0]   vec_q [LAT];

    // Valid bits shift one stage per cycle; a flush empties the whole line.
    // NOTE: sequential state is written with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= valid_i & ~flush_i;
        for (int i = 1; i < LAT; i++) begin
          valid_q[i] <= valid_q[i-1] & ~flush_i;
        end
      end
    end

    // Vector tags shift alongside the valid bits.
    // NOTE: the data lanes have no reset; the valid bits qualify them, so stale contents are never used.
    always_ff @(posedge clk) begin
      vec_q[0] <= vec_i;
      for (int i = 1; i < LAT; i++) begin
        vec_q[i] <= vec_q[i-1];
      end
    end

    assign valid_o   = valid_q[LAT-1];
    assign vec_o     = vec_q[LAT-1];
    assign pending_o = |valid_q;
  end

endmodule

// File: rtl/adder_err_sweep_ctrl.sv
// Exhaustive error sweep of one approximate adder: issues every input vector,
// compares the DUT result with the exact a+b and accumulates error statistics.
module adder_err_sweep_ctrl
  import adder_eval_pkg::*;
#(
  parameter int IN_W         = DEF_IN_W,
  parameter int OUT_W        = out_w_for(IN_W),
  parameter int ET           = 3,
  parameter int DUT_LAT      = 0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_count,
  output logic [IN_W+OUT_W-1:0] sum_abs_err,
  output logic                  fail_seen,
  output logic [IN_W-1:0]       first_fail_vec
);

  localparam int                HALF_W   = IN_W / 2;
  localparam int                ACC_W    = acc_w_for(IN_W, OUT_W);
  localparam logic [IN_W-1:0]   LAST_VEC = '1;
  localparam logic [OUT_W-1:0]  ET_L     = OUT_W'(ET);

  // Sequencer state.
  sweep_state_e    state_q, state_d;
  logic [IN_W-1:0] vec_q, vec_d;
  logic            kill_q, kill_d;

  // Error stage: |err| of one vector, registered one cycle after sampling.
  logic            err_valid_q, err_valid_d;
  logic [OUT_W-1:0] err_q, err_d;
  logic [IN_W-1:0] err_vec_q;

  // Statistics.
  logic [OUT_W-1:0] max_err_q, max_err_d;
  logic [IN_W:0]    err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             fail_seen_q, fail_seen_d;
  logic [IN_W-1:0]  ffv_q, ffv_d;
  logic             pass_q, pass_d;

  // Control decodes.
  logic            issue;
  logic            accept;
  logic            abort_now;
  logic            tag_valid;
  logic [IN_W-1:0] tag_vec;
  logic            pipe_pending;
  logic            acc_en;
  logic            is_fail;
  logic            fail_now;

  assign issue     = (state_q == SWEEP);
  assign accept    = (state_q == IDLE) && start;
  assign abort_now = abort && ((state_q == SWEEP) || (state_q == DRAIN));

  // Tags follow the DUT latency so a+b is rebuilt from the matching vector.
  sweep_tag_pipe #(
    .LAT (DUT_LAT),
    .W   (IN_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (abort_now),
    .valid_i   (issue),
    .vec_i     (vec_q),
    .valid_o   (tag_valid),
    .vec_o     (tag_vec),
    .pending_o (pipe_pending)
  );

  // Error unit: exact sum zero-extended to OUT_W, difference taken one bit wider.
  logic [OUT_W-1:0] exact;
  logic [OUT_W:0]   diff;
  logic [OUT_W:0]   abs_full;
  logic             unused_abs_msb;

  assign exact          = {1'b0, tag_vec[IN_W-1:HALF_W]} + {1'b0, tag_vec[HALF_W-1:0]};
  assign diff           = {1'b0, dut_out} - {1'b0, exact};
  assign abs_full       = diff[OUT_W] ? -diff : diff;
  assign err_d          = abs_full[OUT_W-1:0];
  assign unused_abs_msb = abs_full[OUT_W];
  assign err_valid_d    = tag_valid && !abort_now;

  // Once a stop-on-fail has been taken, later in-flight results are discarded.
  assign acc_en   = err_valid_q && !kill_q && !abort_now;
  assign is_fail  = (err_q > ET_L);
  assign fail_now = acc_en && is_fail;
  assign kill_d   = accept ? 1'b0 : (kill_q | (STOP_ON_FAIL & fail_now));

  // Next-state and vector counter.
  // NOTE: every variable gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          vec_d   = '0;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (STOP_ON_FAIL && fail_now) begin
          state_d = DRAIN;
        end else if (vec_q == LAST_VEC) begin
          state_d = DRAIN;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pipe_pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Statistics update: clear on an accepted start, accumulate one vector per cycle.
  always_comb begin
    max_err_d   = max_err_q;
    err_count_d = err_count_q;
    sum_d       = sum_q;
    fail_seen_d = fail_seen_q;
    ffv_d       = ffv_q;
    pass_d      = pass_q;
    if (accept) begin
      max_err_d   = '0;
      err_count_d = '0;
      sum_d       = '0;
      fail_seen_d = 1'b0;
      ffv_d       = '0;
      pass_d      = 1'b0;
    end else if (acc_en) begin
      if (err_q != '0) begin
        err_count_d = err_count_q + 1'b1;
      end
      sum_d = sum_q + ACC_W'(err_q);
      if (err_q > max_err_q) begin
        max_err_d = err_q;
      end
      // Vectors arrive in ascending order, so the first fail is the lowest one.
      if (is_fail && !fail_seen_q) begin
        fail_seen_d = 1'b1;
        ffv_d       = err_vec_q;
      end
    end
    // The verdict is latched together with the final accumulation.
    if ((state_q == DRAIN) && (state_d == DONE)) begin
      pass_d = (max_err_d <= ET_L);
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      kill_q  <= kill_d;
    end
  end

  // Error stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_q       <= '0;
      err_vec_q   <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_q       <= err_d;
      err_vec_q   <= tag_vec;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err_q   <= '0;
      err_count_q <= '0;
      sum_q       <= '0;
      fail_seen_q <= 1'b0;
      ffv_q       <= '0;
      pass_q      <= 1'b0;
    end else begin
      max_err_q   <= max_err_d;
      err_count_q <= err_count_d;
      sum_q       <= sum_d;
      fail_seen_q <= fail_seen_d;
      ffv_q       <= ffv_d;
      pass_q      <= pass_d;
    end
  end

  assign dut_in         = vec_q;
  assign busy           = (state_q == SWEEP) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign max_err        = max_err_q;
  assign err_count      = err_count_q;
  assign sum_abs_err    = sum_q;
  assign fail_seen      = fail_seen_q;
  assign first_fail_vec = ffv_q;

endmodule
